// File: rtl/add_pkg.sv
// Shared definitions for the pipelined adder: slice sizing and parameter legality.
package add_pkg;

    function automatic int unsigned slice_width(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

    // Legal when every stage owns an equal, non-empty slice of the carry chain.
    function automatic bit params_ok(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational ripple of W full adders; also exports the carry into its MSB.
module add_slice #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         ci,
    output logic [W-1:0] s_o,
    output logic         co_o,
    output logic         cmsb_o
);

    logic [W:0] w_c;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        w_c    = '0;
        s_o    = '0;
        w_c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s_o[i]   = a_i[i] ^ b_i[i] ^ w_c[i];
            w_c[i+1] = (a_i[i] & b_i[i]) | (w_c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign co_o   = w_c[W];
    assign cmsb_o = w_c[W-1];

endmodule

// File: rtl/add_pipe.sv
// Pipelined ripple-carry adder/subtractor; one carry slice resolved per stage,
// all stages advance together under a single global enable.
module add_pipe
    import add_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int unsigned W = slice_width(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_param_check
        $fatal(1, "add_pipe: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    logic             w_en;
    logic [WIDTH-1:0] w_bb;
    logic             w_cin;
    logic             w_ovf_nxt;

    // Stage k register holds the result of slices 0..k plus the operands still to add.
    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_c [STAGES];
    logic             r_v [STAGES];
    logic             r_ovf;

    logic [WIDTH-1:0] w_a_src [STAGES];
    logic [WIDTH-1:0] w_b_src [STAGES];
    logic [WIDTH-1:0] w_s_src [STAGES];
    logic [WIDTH-1:0] w_s_nxt [STAGES];
    logic             w_c_src [STAGES];
    logic             w_v_src [STAGES];
    logic [W-1:0]     w_ss    [STAGES];
    logic             w_co    [STAGES];
    logic             w_cmsb  [STAGES];

    assign w_bb  = sub ? ~b : b;
    assign w_cin = sub | ci;

    assign w_en     = ~out_valid | out_ready;
    assign in_ready = w_en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_a_src[k] = a;
            assign w_b_src[k] = w_bb;
            assign w_c_src[k] = w_cin;
            assign w_s_src[k] = '0;
            assign w_v_src[k] = in_valid;
        end else begin : g_rest
            assign w_a_src[k] = r_a[k-1];
            assign w_b_src[k] = r_b[k-1];
            assign w_c_src[k] = r_c[k-1];
            assign w_s_src[k] = r_s[k-1];
            assign w_v_src[k] = r_v[k-1];
        end

        add_slice #(.W(W)) u_slice (
            .a_i    (w_a_src[k][k*W +: W]),
            .b_i    (w_b_src[k][k*W +: W]),
            .ci     (w_c_src[k]),
            .s_o    (w_ss[k]),
            .co_o   (w_co[k]),
            .cmsb_o (w_cmsb[k])
        );

        // Bits of slice k are still zero on entry, so OR-ing the new slice in is enough.
        assign w_s_nxt[k] = w_s_src[k] | (WIDTH'(w_ss[k]) << (k*W));
    end

    assign w_ovf_nxt = w_co[STAGES-1] ^ w_cmsb[STAGES-1];

    // NOTE: state uses non-blocking assignments; every stage, data included, is reset
    // so no stale sum can leak out after a mid-flight reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
                r_v[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_en) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= w_a_src[k];
                r_b[k] <= w_b_src[k];
                r_s[k] <= w_s_nxt[k];
                r_c[k] <= w_co[k];
                r_v[k] <= w_v_src[k];
            end
            r_ovf <= w_ovf_nxt;
        end
    end

    assign out_valid = r_v[STAGES-1];
    assign s         = r_s[STAGES-1];
    assign co        = r_c[STAGES-1];
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_add_pipe.sv
// Self-checking bench for add_pipe (WIDTH=16, STAGES=4): directed table, streaming
// with stall, randomized traffic against an arithmetic model, and mid-flight reset.
module tb_add_pipe;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    add_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ovf;
    } exp_t;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ci;
        logic             sub;
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ovf;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t model_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the effective operands.
    function automatic exp_t model(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                                   input logic xci, input logic xsub);
        exp_t             e;
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   t;
        bb    = xsub ? ~xb : xb;
        t     = {1'b0, xa} + {1'b0, bb} + (WIDTH+1)'(xsub ? 1'b1 : xci);
        e.s   = t[WIDTH-1:0];
        e.co  = t[WIDTH];
        e.ovf = (xa[WIDTH-1] == bb[WIDTH-1]) && (t[WIDTH-1] != xa[WIDTH-1]);
        return e;
    endfunction

    // Called just before the rising edge: account for the transfers that edge performs.
    task automatic monitor();
        exp_t e;
        if (out_valid && out_ready) begin
            if (model_q.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'(0));
            end else begin
                e = model_q.pop_front();
                check("model_s", 32'(s), 32'(e.s));
                check("model_co", 32'(co), 32'(e.co));
                check("model_ovf", 32'(ovf), 32'(e.ovf));
            end
        end
        if (in_valid && in_ready) model_q.push_back(model(a, b, ci, sub));
    endtask

    task automatic tick();
        #1;
        monitor();
        @(negedge clk);
    endtask

    vec_t vecs[8];

    initial begin
        int lat;
        int sent;
        int got;
        int stall_left;
        bit stall_done;
        int seen;

        vecs[0] = '{"add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{"ovf_pos",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{"ovf_neg",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[3] = '{"sub_borrow",16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{"sub_pos",   16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[5] = '{"sub_ci_ign",16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[6] = '{"carry_in",  16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[7] = '{"sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_s", 32'(s), 32'(0));
        check("rst_co", 32'(co), 32'(0));
        check("rst_ovf", 32'(ovf), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table: one beat at a time, latency and value checked.
        for (int i = 0; i < 8; i++) begin
            a = vecs[i].a; b = vecs[i].b; ci = vecs[i].ci; sub = vecs[i].sub;
            in_valid = 1'b1; out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 10) begin
                tick();
                lat++;
            end
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(STAGES-1));
            check({vecs[i].name, "_s"}, 32'(s), 32'(vecs[i].s));
            check({vecs[i].name, "_co"}, 32'(co), 32'(vecs[i].co));
            check({vecs[i].name, "_ovf"}, 32'(ovf), 32'(vecs[i].ovf));
            tick();
        end

        // Streaming six beats with a three-cycle stall after the first result.
        sent = 0; got = 0; stall_left = 0; stall_done = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            if (out_valid && !stall_done) begin
                stall_left = 3;
                stall_done = 1'b1;
            end
            out_ready = (stall_left == 0);
            in_valid  = (sent < 6);
            a = 16'(sent); b = 16'(sent + 1); ci = 1'b0; sub = 1'b0;
            #1;
            if (stall_left > 0) begin
                check("stall_in_ready", 32'(in_ready), 32'(0));
                check("stall_s", 32'(s), 32'(1));
                check("stall_out_valid", 32'(out_valid), 32'(1));
                stall_left--;
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                check("stream_order", 32'(s), 32'(2*got + 1));
                got++;
            end
            monitor();
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("stream_sent", 32'(sent), 32'(6));
        check("stream_got", 32'(got), 32'(6));
        check("stream_stalled", 32'(stall_done), 32'(1));

        // Randomized traffic with random backpressure.
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            a   = 16'($urandom);
            b   = 16'($urandom);
            ci  = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && model_q.size() > 0; cyc++) tick();
        check("drain_empty", 32'(model_q.size()), 32'(0));

        // Reset while beats are in flight and a result is presented under stall.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 16'(100 + i); b = 16'(i); ci = 1'b0; sub = 1'b0;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        check("pre_rst_valid", 32'(out_valid), 32'(1));
        check("pre_rst_in_ready", 32'(in_ready), 32'(0));
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        check("midrst_s", 32'(s), 32'(0));
        model_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (out_valid) seen++;
            tick();
        end
        check("no_stale_out", 32'(seen), 32'(0));

        a = 16'h1234; b = 16'h0001; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("post_rst_lat", 32'(lat), 32'(STAGES-1));
        check("post_rst_s", 32'(s), 32'(16'h1235));
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/add_pipe.md
# add_pipe

Parametrised, pipelined ripple-carry adder/subtractor built from registered slices of full adders. One operation is accepted per cycle under a valid/ready handshake, and the result appears after a fixed latency of STAGES cycles. It serves arithmetic datapaths that need widths beyond a single full adder and need timing closure through a long carry chain.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of STAGES
- STAGES, 4, pipeline depth; each stage resolves WIDTH/STAGES bits of the carry chain; 1 ≤ STAGES ≤ WIDTH
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ci  in  1  carry-in; ignored when sub=1
- sub  in  1  0 = add, 1 = subtract (a − b)
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts the result
- s  out  WIDTH  sum or difference
- co  out  1  carry-out of the MSB (for subtract: 1 = no borrow)
- ovf  out  1  two's-complement signed overflow

## Operation
- Effective operands:
  - bb = sub ? ~b : b
  - cin = sub ? 1 : ci
  - Result {co, s} = a + bb + cin, modulo 2^(WIDTH+1).
- Stage k (0..STAGES−1) adds bits [k·W+W−1 : k·W], where W = WIDTH/STAGES, using the carry registered out of stage k−1. Stage 0 uses cin.
- Each stage register carries:
  - the not-yet-added upper operand bits
  - the already-computed lower sum bits
  - the slice carry
  - a valid bit
- ovf = carry into the MSB XOR carry out of the MSB. It is computed in the last stage.
- Flow control is a single global enable:
  - en = ~out_valid | out_ready
  - in_ready = en
  - When en=1, every stage shifts forward and stage 0 loads {a, bb, cin, in_valid}.
  - When en=0, all stages hold.
- Bubbles are not collapsed. A stage with valid=0 still occupies its slot.
- An input transfer occurs on in_valid & in_ready. An output transfer occurs on out_valid & out_ready.
- Operands are captured only at the input transfer. Later changes to a, b, ci or sub have no effect on in-flight beats.

## Timing
- Reset (rst_n=0, asynchronous): all valid bits clear and all data registers clear. Outputs are:
  - out_valid=0, s=0, co=0, ovf=0
  - in_ready=1
- Reset has priority over everything, including mid-flight beats, which are discarded. The first accept is allowed on the first rising edge after rst_n deasserts.
- Latency: a beat accepted at edge n presents out_valid=1 with its result after edge n+STAGES−1. It stays presented until the edge where out_ready=1.
- Throughput: one beat per cycle while out_ready stays high.
- Stall: while out_valid=1 and out_ready=0, the pipeline holds, in_ready=0, and s/co/ovf are stable.
- Simultaneous events: with out_valid=1 and out_ready=1, a new input is accepted in the same cycle as the output is consumed. No dead cycle is allowed.
- in_ready depends combinationally on out_ready. No other combinational input-to-output path is allowed.
- STAGES=1 degenerates to a single registered full-width adder with latency 1.

## Structure
- Sub-module add_slice: combinational ripple of W full adders. Inputs are a_i, b_i and ci; outputs are s_o and co_o. It also exports the carry into its MSB, which the last slice uses for ovf. Instantiated STAGES times via generate.
- A shared package add_pkg holds:
  - the slice-width constant function (WIDTH/STAGES)
  - the elaboration-time check that WIDTH % STAGES == 0 and STAGES ≤ WIDTH, which must fail the build if violated
- No state machine beyond the per-stage valid shift chain.

## Test plan
All scenarios use WIDTH=16, STAGES=4.
- Add wrap: a=0xFFFF, b=0x0001, ci=0, sub=0 → after 4 cycles s=0x0000, co=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, ci=0 → s=0x8000, co=0, ovf=1. Also a=0x8000, b=0x8000 → s=0x0000, co=1, ovf=1.
- Subtract with ci ignored: a=0x0005, b=0x0007, sub=1, ci=0 → s=0xFFFE, co=0, ovf=0. Then a=0x0007, b=0x0005, sub=1 → s=0x0002, co=1.
- Carry-in: a=0x00FF, b=0x0000, ci=1 → s=0x0100, co=0.
- Streaming plus stall:
  - Send 6 back-to-back beats with operand values i and i+1 (i=0..5).
  - Hold out_ready=0 for 3 cycles after the first out_valid.
  - Required: in_ready=0 during the stall, results 1,3,5,7,9,11 delivered in order, none lost or duplicated.
- Reset mid-flight: pulse rst_n low asynchronously while 3 beats are in flight → out_valid=0 and in_ready=1 immediately. No stale result appears after release.
